qpsk_frame_ctrl: RTL and testbench
==================================

Name: qpsk_frame_ctrl

Overview:
- Sequences reception of framed QPSK data: 2-bit symbols arrive from the demodulator.
- Hunts for a 32-bit sync word, then packs symbols into 32-bit words.
- Parses a length header, forwards payload words with framing flags, and verifies a trailing XOR checksum.
- Sits between the symbol demodulator and the packet buffer/command decoder; replaces free-running word collection with frame-aligned collection.

Parameters:
- SYNC, 32'h1ACF_FC1D, sync word; must be nonzero.
- MAX_WORDS, 64, maximum payload words per frame (1..255).
- TIMEOUT, 1000, consecutive idle CLK cycles without valid_i that abort a frame in progress (2..65535).

Ports:
- CLK  in  1  clock
- RST  in  1  reset, asynchronous, active-low
- enable_i  in  1  0 forces HUNT, drops symbols, silent abort
- valid_i  in  1  symbol strobe, at most one symbol per cycle
- data_i  in  2  QPSK symbol
- word_valid_o  out  1  payload word strobe, one cycle
- word_o  out  32  payload word, held until the next strobe
- sof_o  out  1  with word_valid_o on first payload word
- eof_o  out  1  with word_valid_o on last payload word
- frame_done_o  out  1  one-cycle pulse after the checksum word
- frame_ok_o  out  1  checksum result, held until the next frame_done_o
- err_o  out  1  one-cycle abort pulse
- err_code_o  out  2  1=bad length, 2=timeout; held until the next err_o
- busy_o  out  1  state != HUNT

Behaviour:
- Reset: state=HUNT. All outputs 0, word_o=0. Shift register, symbol counter, idle counter, word counter and XOR accumulator all 0.
- Packing: on valid_i, sr <= {data_i, sr[31:2]}. The first symbol of a word lands in bits [1:0] of the completed word.
- Symbol counter: 0..15; wraps to 0 on the 16th symbol, which completes a word.
- HUNT:
  - On entry, sr and the hunt fill count clear.
  - Match when the shifted value == SYNC, at least 16 symbols have been received since entry, and enable_i=1.
  - On match -> HEADER, symbol counter=0.
  - Sync search is bit-pair sliding, not word aligned.
- HEADER:
  - On word completion, N = word[7:0]; word[31:8] ignored.
  - If N==0 or N>MAX_WORDS -> err_o pulse, err_code_o=1, -> HUNT.
  - Otherwise store N, clear the accumulator and word counter, -> PAYLOAD.
- PAYLOAD:
  - Each completed word drives word_valid_o=1 and word_o=word on the next cycle (latency 1 cycle from the 16th valid_i).
  - acc ^= word; word counter increments.
  - sof_o is set when word counter==0.
  - eof_o is set when word counter==N-1; that word moves the state -> CHECK. N=1 gives sof_o and eof_o together.
- CHECK:
  - On word completion: frame_done_o pulse, frame_ok_o=(word==acc), -> HUNT.
  - The checksum word is not output on word_o.
- Idle counter (HEADER/PAYLOAD/CHECK only):
  - Clears on valid_i; increments otherwise.
  - When it reaches TIMEOUT: err_o pulse, err_code_o=2, -> HUNT.
  - valid_i in the cycle that would reach TIMEOUT cancels the abort.
  - Counter is held at 0 in HUNT.
- enable_i=0 in any state:
  - Next cycle state=HUNT, partial word discarded, no err_o and no frame_done_o.
  - eof_o is never emitted for the aborted frame; downstream drops frames lacking frame_done_o.
- Pulse outputs never overlap in one cycle. word_valid_o, frame_done_o and err_o are mutually exclusive by construction.
- Symbols arriving in the same cycle as a state transition belong to the new state. A sync-match symbol is consumed by HUNT only.

Test Plan:
1. Good frame:
   - Stimulus: 0x1ACFFC1D, header 0x00000003, payload 0x11111111, 0x22222222, 0x44444444, checksum 0x77777777.
   - Response: 3 word_valid_o (sof_o on 1st, eof_o on 3rd), word_o values match, frame_done_o=1, frame_ok_o=1.
2. Bad checksum:
   - Stimulus: same frame with checksum 0x77777776.
   - Response: 3 words delivered, frame_done_o with frame_ok_o=0.
3. Bad length:
   - Stimulus: header 0x00000000, then a separate frame with header 0x00000041 (MAX_WORDS=64).
   - Response: err_o with err_code_o=1 each time, no word_valid_o, busy_o=0 after.
4. Timeout:
   - Stimulus: stall valid_i for 999 cycles mid-payload, resume; later stall for 1000 cycles.
   - Response: first stall is no abort and the frame completes ok; second gives err_o with err_code_o=2 on exactly the 1000th idle cycle.
5. Misaligned sync:
   - Stimulus: 7 random symbols preceding the sync, plus a partial sync pattern inside noise.
   - Response: lock only on the full SYNC; payload words bit-exact.
6. Reset and enable abort:
   - Stimulus: drop enable_i mid-payload; separately assert RST mid-frame.
   - Response: HUNT, no err_o, no frame_done_o, all outputs 0 after RST. A subsequent good frame is received correctly.

Source files
------------

// File: rtl/qpsk_frame_ctrl.sv
// Frame-aligned QPSK receive sequencer: hunts a sliding sync word, then parses
// a length header, forwards payload words with SOF/EOF and checks an XOR checksum.
module qpsk_frame_ctrl #(
  parameter logic [31:0] SYNC      = 32'h1ACF_FC1D,
  parameter int          MAX_WORDS = 64,
  parameter int          TIMEOUT   = 1000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        enable_i,
  input  logic        valid_i,
  input  logic [1:0]  data_i,
  output logic        word_valid_o,
  output logic [31:0] word_o,
  output logic        sof_o,
  output logic        eof_o,
  output logic        frame_done_o,
  output logic        frame_ok_o,
  output logic        err_o,
  output logic [1:0]  err_code_o,
  output logic        busy_o
);

  typedef enum logic [1:0] {
    S_HUNT    = 2'd0,
    S_HEADER  = 2'd1,
    S_PAYLOAD = 2'd2,
    S_CHECK   = 2'd3
  } state_t;

  localparam logic [7:0]  MAX_LEN   = 8'(MAX_WORDS);
  localparam logic [15:0] IDLE_LAST = 16'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [31:0] sr_q, sr_d;
  logic [3:0]  sym_cnt_q, sym_cnt_d;
  logic [4:0]  fill_q, fill_d;
  logic [15:0] idle_q, idle_d;
  logic [7:0]  wcnt_q, wcnt_d;
  logic [7:0]  len_q, len_d;
  logic [31:0] acc_q, acc_d;
  logic        word_valid_q, word_valid_d;
  logic [31:0] word_q, word_d;
  logic        sof_q, sof_d;
  logic        eof_q, eof_d;
  logic        done_q, done_d;
  logic        ok_q, ok_d;
  logic        err_q, err_d;
  logic [1:0]  err_code_q, err_code_d;
  logic        busy_q, busy_d;

  logic [31:0] shifted;
  logic [7:0]  hdr_len;

  assign shifted = {data_i, sr_q[31:2]};
  assign hdr_len = shifted[7:0];

  always_comb begin
    state_d      = state_q;
    sr_d         = sr_q;
    sym_cnt_d    = sym_cnt_q;
    fill_d       = fill_q;
    idle_d       = idle_q;
    wcnt_d       = wcnt_q;
    len_d        = len_q;
    acc_d        = acc_q;
    word_valid_d = 1'b0;
    word_d       = word_q;
    sof_d        = 1'b0;
    eof_d        = 1'b0;
    done_d       = 1'b0;
    ok_d         = ok_q;
    err_d        = 1'b0;
    err_code_d   = err_code_q;

    if (!enable_i) begin
      // silent abort: symbol dropped, partial word and hunt history discarded
      state_d   = S_HUNT;
      sr_d      = '0;
      fill_d    = '0;
      sym_cnt_d = '0;
      idle_d    = '0;
    end else if (state_q == S_HUNT) begin
      idle_d = '0;
      if (valid_i) begin
        sr_d = shifted;
        if (fill_q != 5'd16) fill_d = fill_q + 5'd1;
        if ((shifted == SYNC) && (fill_q >= 5'd15)) begin
          state_d   = S_HEADER;
          sym_cnt_d = '0;
        end
      end
    end else if (valid_i) begin
      idle_d    = '0;
      sr_d      = shifted;
      sym_cnt_d = sym_cnt_q + 4'd1;
      if (sym_cnt_q == 4'd15) begin
        case (state_q)
          S_HEADER: begin
            if ((hdr_len == 8'd0) || (hdr_len > MAX_LEN)) begin
              err_d      = 1'b1;
              err_code_d = 2'd1;
              state_d    = S_HUNT;
            end else begin
              len_d   = hdr_len;
              acc_d   = '0;
              wcnt_d  = '0;
              state_d = S_PAYLOAD;
            end
          end
          S_PAYLOAD: begin
            word_valid_d = 1'b1;
            word_d       = shifted;
            acc_d        = acc_q ^ shifted;
            wcnt_d       = wcnt_q + 8'd1;
            sof_d        = (wcnt_q == 8'd0);
            if (wcnt_q == len_q - 8'd1) begin
              eof_d   = 1'b1;
              state_d = S_CHECK;
            end
          end
          default: begin
            done_d  = 1'b1;
            ok_d    = (shifted == acc_q);
            state_d = S_HUNT;
          end
        endcase
      end
    end else if (idle_q == IDLE_LAST) begin
      err_d      = 1'b1;
      err_code_d = 2'd2;
      state_d    = S_HUNT;
    end else begin
      idle_d = idle_q + 16'd1;
    end

    // every way back into HUNT restarts the sync search from scratch
    if ((state_d == S_HUNT) && (state_q != S_HUNT)) begin
      sr_d      = '0;
      fill_d    = '0;
      sym_cnt_d = '0;
      idle_d    = '0;
    end

    busy_d = (state_d != S_HUNT);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q      <= S_HUNT;
      sr_q         <= '0;
      sym_cnt_q    <= '0;
      fill_q       <= '0;
      idle_q       <= '0;
      wcnt_q       <= '0;
      len_q        <= '0;
      acc_q        <= '0;
      word_valid_q <= 1'b0;
      word_q       <= '0;
      sof_q        <= 1'b0;
      eof_q        <= 1'b0;
      done_q       <= 1'b0;
      ok_q         <= 1'b0;
      err_q        <= 1'b0;
      err_code_q   <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      sr_q         <= sr_d;
      sym_cnt_q    <= sym_cnt_d;
      fill_q       <= fill_d;
      idle_q       <= idle_d;
      wcnt_q       <= wcnt_d;
      len_q        <= len_d;
      acc_q        <= acc_d;
      word_valid_q <= word_valid_d;
      word_q       <= word_d;
      sof_q        <= sof_d;
      eof_q        <= eof_d;
      done_q       <= done_d;
      ok_q         <= ok_d;
      err_q        <= err_d;
      err_code_q   <= err_code_d;
      busy_q       <= busy_d;
    end
  end

  assign word_valid_o = word_valid_q;
  assign word_o       = word_q;
  assign sof_o        = sof_q;
  assign eof_o        = eof_q;
  assign frame_done_o = done_q;
  assign frame_ok_o   = ok_q;
  assign err_o        = err_q;
  assign err_code_o   = err_code_q;
  assign busy_o       = busy_q;

endmodule

// File: tb/tb_qpsk_frame_ctrl.sv
// Bench for qpsk_frame_ctrl: queue-based frame model checked every cycle,
// plus literal expectations on the delivered words and status of each scenario.
module tb_qpsk_frame_ctrl;

  localparam logic [31:0] SYNC      = 32'h1ACF_FC1D;
  localparam int          MAX_WORDS = 64;
  localparam int          TIMEOUT   = 1000;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        enable_i = 1'b1;
  logic        valid_i = 1'b0;
  logic [1:0]  data_i = 2'd0;
  logic        word_valid_o;
  logic [31:0] word_o;
  logic        sof_o, eof_o, frame_done_o, frame_ok_o, err_o, busy_o;
  logic [1:0]  err_code_o;

  qpsk_frame_ctrl #(.SYNC(SYNC), .MAX_WORDS(MAX_WORDS), .TIMEOUT(TIMEOUT)) dut (
    .CLK(CLK), .RST(RST), .enable_i(enable_i), .valid_i(valid_i), .data_i(data_i),
    .word_valid_o(word_valid_o), .word_o(word_o), .sof_o(sof_o), .eof_o(eof_o),
    .frame_done_o(frame_done_o), .frame_ok_o(frame_ok_o), .err_o(err_o),
    .err_code_o(err_code_o), .busy_o(busy_o)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // model state: mode 0=searching, 1=expect length, 2=payload, 3=expect checksum
  int          m_mode = 0;
  int          m_idle = 0;
  int          m_len = 0;
  int          m_cnt = 0;
  logic [31:0] m_acc = 0;
  logic [31:0] m_w;
  logic [1:0]  hq[$];
  logic [1:0]  pq[$];
  logic        e_wv = 0, e_sof = 0, e_eof = 0, e_done = 0, e_ok = 0, e_err = 0;
  logic [1:0]  e_code = 0;
  logic [31:0] e_word = 0;

  // observed events for literal checks
  logic [31:0] got_w[$];
  logic [1:0]  got_f[$];
  int          done_cnt = 0, err_cnt = 0, eof_cnt = 0;
  logic        last_ok = 0;
  logic [1:0]  last_code = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  initial forever begin
    @(posedge CLK or negedge RST);
    if (!RST) begin
      m_mode = 0; m_idle = 0; hq.delete(); pq.delete();
      e_wv = 0; e_sof = 0; e_eof = 0; e_done = 0; e_ok = 0; e_err = 0; e_code = 0; e_word = 0;
    end else begin
      e_wv = 0; e_sof = 0; e_eof = 0; e_done = 0; e_err = 0;
      if (!enable_i) begin
        m_mode = 0; m_idle = 0; hq.delete(); pq.delete();
      end else if (m_mode == 0) begin
        if (valid_i) begin
          hq.push_back(data_i);
          if (hq.size() > 16) void'(hq.pop_front());
          if (hq.size() == 16) begin
            m_w = 0;
            foreach (hq[i]) m_w = m_w | (32'(hq[i]) << (2 * i));
            if (m_w == SYNC) begin m_mode = 1; pq.delete(); m_idle = 0; end
          end
        end
      end else if (valid_i) begin
        m_idle = 0;
        pq.push_back(data_i);
        if (pq.size() == 16) begin
          m_w = 0;
          foreach (pq[i]) m_w = m_w | (32'(pq[i]) << (2 * i));
          pq.delete();
          if (m_mode == 1) begin
            if ((m_w % 256) == 0 || (m_w % 256) > MAX_WORDS) begin
              e_err = 1; e_code = 1; m_mode = 0; hq.delete();
            end else begin
              m_len = int'(m_w % 256); m_cnt = 0; m_acc = 0; m_mode = 2;
            end
          end else if (m_mode == 2) begin
            e_wv = 1; e_word = m_w; e_sof = (m_cnt == 0);
            m_acc = m_acc ^ m_w; m_cnt++;
            if (m_cnt == m_len) begin e_eof = 1; m_mode = 3; end
          end else begin
            e_done = 1; e_ok = (m_w == m_acc); m_mode = 0; hq.delete();
          end
        end
      end else begin
        m_idle++;
        if (m_idle == TIMEOUT) begin
          e_err = 1; e_code = 2; m_mode = 0; m_idle = 0; hq.delete(); pq.delete();
        end
      end
    end
  end

  // per-cycle compare against the model, plus event capture
  initial forever begin
    @(negedge CLK);
    checks++;
    if ({word_valid_o, sof_o, eof_o, frame_done_o, frame_ok_o, err_o, err_code_o, busy_o, word_o} !==
        {e_wv, e_sof, e_eof, e_done, e_ok, e_err, e_code, (m_mode != 0), e_word}) begin
      errors++;
      if (errors < 30)
        $display("FAIL cycle t=%0t got wv%b sof%b eof%b done%b ok%b err%b code%0d busy%b word %h want wv%b sof%b eof%b done%b ok%b err%b code%0d busy%b word %h",
                 $time, word_valid_o, sof_o, eof_o, frame_done_o, frame_ok_o, err_o, err_code_o, busy_o, word_o,
                 e_wv, e_sof, e_eof, e_done, e_ok, e_err, e_code, (m_mode != 0), e_word);
    end
    if (word_valid_o) begin got_w.push_back(word_o); got_f.push_back({sof_o, eof_o}); end
    if (eof_o) eof_cnt++;
    if (frame_done_o) begin done_cnt++; last_ok = frame_ok_o; end
    if (err_o) begin err_cnt++; last_code = err_code_o; end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic send_sym(input logic [1:0] s);
    valid_i = 1'b1; data_i = s;
    tick();
    valid_i = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 16; i++) send_sym(w[2*i +: 2]);
  endtask

  task automatic idle(input int n);
    valid_i = 1'b0;
    repeat (n) tick();
  endtask

  task automatic clear_mon();
    got_w.delete(); got_f.delete();
    done_cnt = 0; err_cnt = 0; eof_cnt = 0;
  endtask

  function automatic logic [31:0] gw(input int i);
    return (got_w.size() > i) ? got_w[i] : 32'hBAD0_0000;
  endfunction

  function automatic logic [1:0] gf(input int i);
    return (got_f.size() > i) ? got_f[i] : 2'b11;
  endfunction

  logic [1:0] noise[7] = '{2'd3, 2'd0, 2'd2, 2'd1, 2'd3, 2'd3, 2'd0};
  logic [31:0] sync_v;

  initial begin
    sync_v = SYNC;
    repeat (3) tick();
    chk("reset_word", word_o, 32'h0);
    chk("reset_flags", {word_valid_o, sof_o, eof_o, frame_done_o, frame_ok_o, err_o, err_code_o, busy_o}, 32'h0);
    RST = 1'b1;
    tick();

    // good frame
    clear_mon();
    send_word(SYNC); send_word(32'h0000_0003);
    send_word(32'h1111_1111); send_word(32'h2222_2222); send_word(32'h4444_4444);
    send_word(32'h7777_7777); idle(3);
    chk("good_count", got_w.size(), 3);
    chk("good_w0", gw(0), 32'h1111_1111);
    chk("good_w1", gw(1), 32'h2222_2222);
    chk("good_w2", gw(2), 32'h4444_4444);
    chk("good_f0", gf(0), 2'b10);
    chk("good_f1", gf(1), 2'b00);
    chk("good_f2", gf(2), 2'b01);
    chk("good_done", done_cnt, 1);
    chk("good_ok", last_ok, 1);
    chk("good_ok_held", frame_ok_o, 1);

    // bad checksum
    clear_mon();
    send_word(SYNC); send_word(32'h0000_0003);
    send_word(32'h1111_1111); send_word(32'h2222_2222); send_word(32'h4444_4444);
    send_word(32'h7777_7776); idle(3);
    chk("badck_count", got_w.size(), 3);
    chk("badck_done", done_cnt, 1);
    chk("badck_ok", last_ok, 0);

    // bad length: zero, then MAX_WORDS+1
    clear_mon();
    send_word(SYNC); send_word(32'h0000_0000); idle(3);
    chk("len0_err", err_cnt, 1);
    chk("len0_code", last_code, 1);
    chk("len0_busy", busy_o, 0);
    send_word(SYNC); send_word(32'hFFFF_FF41); idle(3);
    chk("len65_err", err_cnt, 2);
    chk("len65_code", err_code_o, 1);
    chk("len_words", got_w.size(), 0);
    chk("len_busy", busy_o, 0);

    // single-word frame: sof and eof together
    clear_mon();
    send_word(SYNC); send_word(32'hABCD_EF01);
    send_word(32'hCAFE_F00D); send_word(32'hCAFE_F00D); idle(3);
    chk("n1_word", gw(0), 32'hCAFE_F00D);
    chk("n1_flags", gf(0), 2'b11);
    chk("n1_ok", last_ok, 1);

    // timeout: 999 idle cycles survive, 1000 abort
    clear_mon();
    send_word(SYNC); send_word(32'h0000_0002);
    send_word(32'h1234_5678); idle(TIMEOUT - 1);
    send_word(32'h9ABC_DEF0); send_word(32'h1234_5678 ^ 32'h9ABC_DEF0); idle(3);
    chk("to999_err", err_cnt, 0);
    chk("to999_done", done_cnt, 1);
    chk("to999_ok", last_ok, 1);
    send_word(SYNC); send_word(32'h0000_0002); send_word(32'h1234_5678);
    idle(TIMEOUT - 1);
    chk("to_pre_err", err_o, 0);
    chk("to_pre_busy", busy_o, 1);
    tick();
    chk("to_err", err_o, 1);
    chk("to_code", err_code_o, 2);
    chk("to_busy", busy_o, 0);
    idle(2);

    // misaligned sync with a partial sync inside noise
    clear_mon();
    for (int i = 0; i < 7; i++) send_sym(noise[i]);
    for (int i = 0; i < 12; i++) send_sym(sync_v[2*i +: 2]);
    send_sym(2'd0); send_sym(2'd0);
    chk("mis_hunting", busy_o, 0);
    send_word(SYNC); send_word(32'h0000_0002);
    send_word(32'hDEAD_BEEF); send_word(32'h0123_ABCD); send_word(32'hDF8E_1522); idle(3);
    chk("mis_count", got_w.size(), 2);
    chk("mis_w0", gw(0), 32'hDEAD_BEEF);
    chk("mis_w1", gw(1), 32'h0123_ABCD);
    chk("mis_ok", last_ok, 1);

    // enable drop mid-payload
    clear_mon();
    send_word(SYNC); send_word(32'h0000_0003); send_word(32'h5555_AAAA);
    for (int i = 0; i < 7; i++) send_sym(2'(i));
    enable_i = 1'b0; valid_i = 1'b1; data_i = 2'd3;
    tick();
    enable_i = 1'b1; valid_i = 1'b0;
    chk("en_busy", busy_o, 0);
    idle(5);
    chk("en_words", got_w.size(), 1);
    chk("en_err", err_cnt, 0);
    chk("en_done", done_cnt, 0);
    chk("en_eof", eof_cnt, 0);

    // asynchronous reset mid-frame
    clear_mon();
    send_word(SYNC); send_word(32'h0000_0002); send_word(32'h0F0F_0F0F);
    send_sym(2'd1);
    RST = 1'b0;
    #2;
    chk("rst_word", word_o, 32'h0);
    chk("rst_flags", {word_valid_o, sof_o, eof_o, frame_done_o, frame_ok_o, err_o, err_code_o, busy_o}, 32'h0);
    tick();
    RST = 1'b1;
    tick();
    chk("rst_err", err_cnt, 0);
    chk("rst_done", done_cnt, 0);

    // good frame after reset
    clear_mon();
    send_word(SYNC); send_word(32'h0000_0002);
    send_word(32'hA5A5_0001); send_word(32'h5A5A_0002); send_word(32'hFFFF_0003); idle(3);
    chk("post_count", got_w.size(), 2);
    chk("post_w0", gw(0), 32'hA5A5_0001);
    chk("post_w1", gw(1), 32'h5A5A_0002);
    chk("post_done", done_cnt, 1);
    chk("post_ok", last_ok, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
